// File: rtl/bram_lane_acc_mover.sv
// bram_lane_acc_mover
// Streams run_count rows out of BRAM0, splits every row into NUM_LANES unsigned
// lanes and keeps one wrapping running sum per lane. The sums are written to BRAM1
// either after every row (mode 0) or once, after the last row (mode 1).
module bram_lane_acc_mover #(
   parameter int NUM_LANES = 4,
   parameter int IN_W      = 8,
   parameter int ACC_W     = 32,
   parameter int AWIDTH    = 8,
   parameter int CNT_BIT   = 16,
   parameter int RD_LAT    = 1,
   localparam int DWIDTH_IN  = NUM_LANES * IN_W,
   localparam int DWIDTH_OUT = NUM_LANES * ACC_W
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start_i,
   input  logic [CNT_BIT-1:0]    run_count_i,
   input  logic                  mode_i,
   input  logic [AWIDTH-1:0]     rd_base_i,
   input  logic [AWIDTH-1:0]     wr_base_i,
   output logic                  idle_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [AWIDTH-1:0]     addr_b0_o,
   output logic                  ce_b0_o,
   output logic                  we_b0_o,
   input  logic [DWIDTH_IN-1:0]  q_b0_i,
   output logic [AWIDTH-1:0]     addr_b1_o,
   output logic                  ce_b1_o,
   output logic                  we_b1_o,
   output logic [DWIDTH_OUT-1:0] d_b1_o
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_BIT-1:0]  cnt_q, cnt_d;         // rows requested for this run
   logic                mode_q, mode_d;
   logic [AWIDTH-1:0]   rd_base_q, rd_base_d;
   logic [AWIDTH-1:0]   wr_base_q, wr_base_d;
   logic [CNT_BIT-1:0]  rd_cnt_q, rd_cnt_d;   // reads issued so far
   logic [CNT_BIT-1:0]  acc_cnt_q, acc_cnt_d; // rows accumulated so far
   logic [RD_LAT-1:0]   rd_vld_q, rd_vld_d;   // in-flight BRAM0 reads, oldest at MSB
   logic                wr_vld_q, wr_vld_d;   // BRAM1 write pending this cycle
   logic                wr_last_q, wr_last_d; // pending write carries the final sums
   logic [AWIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic [ACC_W-1:0]    acc_q [NUM_LANES];
   logic [ACC_W-1:0]    acc_d [NUM_LANES];
   logic                rd_issue;
   logic                acc_last;

   // Next-state logic for the FSM, the read pipe and the lane accumulators
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mode_d    = mode_q;
      rd_base_d = rd_base_q;
      wr_base_d = wr_base_q;
      rd_cnt_d  = rd_cnt_q;
      acc_cnt_d = acc_cnt_q;
      wr_vld_d  = 1'b0;
      wr_last_d = 1'b0;
      wr_addr_d = wr_addr_q;
      acc_d     = acc_q;
      rd_issue  = 1'b0;
      acc_last  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               cnt_d     = run_count_i;
               mode_d    = mode_i;
               rd_base_d = rd_base_i;
               wr_base_d = wr_base_i;
               rd_cnt_d  = '0;
               acc_cnt_d = '0;
               for (int l = 0; l < NUM_LANES; l++) acc_d[l] = '0;
               state_d   = (run_count_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            rd_issue = 1'b1;
            rd_cnt_d = rd_cnt_q + CNT_BIT'(1);
            if (rd_cnt_q == cnt_q - CNT_BIT'(1)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // The final write is the last thing this run does
            if (wr_vld_q && wr_last_q) state_d = S_DONE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A read issued in cycle t lands at the MSB in cycle t+RD_LAT
      rd_vld_d = RD_LAT'({rd_vld_q, rd_issue});

      if (rd_vld_q[RD_LAT-1]) begin
         for (int l = 0; l < NUM_LANES; l++)
            acc_d[l] = acc_q[l] + ACC_W'(q_b0_i[l*IN_W +: IN_W]);
         acc_last  = (acc_cnt_q == cnt_q - CNT_BIT'(1));
         acc_cnt_d = acc_cnt_q + CNT_BIT'(1);
         wr_last_d = acc_last;
         wr_vld_d  = !mode_q || acc_last;
         wr_addr_d = mode_q ? wr_base_q : wr_base_q + AWIDTH'(acc_cnt_q);
      end
   end

   // State and datapath registers; reset aborts any run immediately
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         mode_q    <= 1'b0;
         rd_base_q <= '0;
         wr_base_q <= '0;
         rd_cnt_q  <= '0;
         acc_cnt_q <= '0;
         rd_vld_q  <= '0;
         wr_vld_q  <= 1'b0;
         wr_last_q <= 1'b0;
         wr_addr_q <= '0;
         for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mode_q    <= mode_d;
         rd_base_q <= rd_base_d;
         wr_base_q <= wr_base_d;
         rd_cnt_q  <= rd_cnt_d;
         acc_cnt_q <= acc_cnt_d;
         rd_vld_q  <= rd_vld_d;
         wr_vld_q  <= wr_vld_d;
         wr_last_q <= wr_last_d;
         wr_addr_q <= wr_addr_d;
         for (int l = 0; l < NUM_LANES; l++) acc_q[l] <= acc_d[l];
      end
   end

   // Output decode; address and data buses are forced to 0 while their enable is low
   always_comb begin
      idle_o    = (state_q == S_IDLE);
      busy_o    = (state_q == S_RUN) || (state_q == S_DRAIN);
      done_o    = (state_q == S_DONE);
      ce_b0_o   = (state_q == S_RUN);
      we_b0_o   = 1'b0;
      addr_b0_o = ce_b0_o ? rd_base_q + AWIDTH'(rd_cnt_q) : '0;
      ce_b1_o   = wr_vld_q;
      we_b1_o   = wr_vld_q;
      addr_b1_o = wr_vld_q ? wr_addr_q : '0;
      d_b1_o    = '0;
      if (wr_vld_q) begin
         for (int l = 0; l < NUM_LANES; l++) d_b1_o[l*ACC_W +: ACC_W] = acc_q[l];
      end
   end

endmodule

// File: tb/tb_bram_lane_acc_mover.sv
// Directed bench for bram_lane_acc_mover. Four instances share one stimulus:
// index 0/1/2 use RD_LAT 1/2/3 with 32-bit sums, index 3 uses RD_LAT 1 with 8-bit sums.
module tb_bram_lane_acc_mover;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic [15:0] run_count = '0;
   logic        mode = 1'b0;
   logic [7:0]  rd_base = '0;
   logic [7:0]  wr_base = '0;

   logic         idle [4];
   logic         busy [4];
   logic         done [4];
   logic         ce0  [4];
   logic         we0  [4];
   logic         ce1  [4];
   logic         we1  [4];
   logic [7:0]   a0   [4];
   logic [7:0]   a1   [4];
   logic [127:0] d1   [4];
   logic [31:0]  d8_raw;
   logic [31:0]  mem0 [256];
   logic [31:0]  pipe [4][3];

   // Logs filled by the monitor (append only)
   int           cyc = 0;
   int           base = 0;
   int           rd_n [4];
   int           wr_n [4];
   int           dn_n [4];
   int           bad  [4];
   logic [7:0]   ra   [4][64];
   logic [7:0]   wa   [4][64];
   logic [127:0] wd   [4][64];
   int           wc   [4][64];
   int           dc   [4][64];
   int           r0 [4];
   int           w0 [4];
   int           n0 [4];

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] EXP_R0 = {32'h1,   32'h2, 32'h3, 32'h4};
   localparam logic [127:0] EXP_R1 = {32'h2,   32'h3, 32'h4, 32'h5};
   localparam logic [127:0] EXP_R2 = {32'h101, 32'h3, 32'h4, 32'h15};

   always #5 clk = ~clk;

   bram_lane_acc_mover #(.RD_LAT(1)) u_l1 (
      .clk(clk), .reset_n(reset_n), .start_i(start), .run_count_i(run_count), .mode_i(mode),
      .rd_base_i(rd_base), .wr_base_i(wr_base), .idle_o(idle[0]), .busy_o(busy[0]), .done_o(done[0]),
      .addr_b0_o(a0[0]), .ce_b0_o(ce0[0]), .we_b0_o(we0[0]), .q_b0_i(pipe[0][0]),
      .addr_b1_o(a1[0]), .ce_b1_o(ce1[0]), .we_b1_o(we1[0]), .d_b1_o(d1[0]));

   bram_lane_acc_mover #(.RD_LAT(2)) u_l2 (
      .clk(clk), .reset_n(reset_n), .start_i(start), .run_count_i(run_count), .mode_i(mode),
      .rd_base_i(rd_base), .wr_base_i(wr_base), .idle_o(idle[1]), .busy_o(busy[1]), .done_o(done[1]),
      .addr_b0_o(a0[1]), .ce_b0_o(ce0[1]), .we_b0_o(we0[1]), .q_b0_i(pipe[1][1]),
      .addr_b1_o(a1[1]), .ce_b1_o(ce1[1]), .we_b1_o(we1[1]), .d_b1_o(d1[1]));

   bram_lane_acc_mover #(.RD_LAT(3)) u_l3 (
      .clk(clk), .reset_n(reset_n), .start_i(start), .run_count_i(run_count), .mode_i(mode),
      .rd_base_i(rd_base), .wr_base_i(wr_base), .idle_o(idle[2]), .busy_o(busy[2]), .done_o(done[2]),
      .addr_b0_o(a0[2]), .ce_b0_o(ce0[2]), .we_b0_o(we0[2]), .q_b0_i(pipe[2][2]),
      .addr_b1_o(a1[2]), .ce_b1_o(ce1[2]), .we_b1_o(we1[2]), .d_b1_o(d1[2]));

   bram_lane_acc_mover #(.RD_LAT(1), .ACC_W(8)) u_a8 (
      .clk(clk), .reset_n(reset_n), .start_i(start), .run_count_i(run_count), .mode_i(mode),
      .rd_base_i(rd_base), .wr_base_i(wr_base), .idle_o(idle[3]), .busy_o(busy[3]), .done_o(done[3]),
      .addr_b0_o(a0[3]), .ce_b0_o(ce0[3]), .we_b0_o(we0[3]), .q_b0_i(pipe[3][0]),
      .addr_b1_o(a1[3]), .ce_b1_o(ce1[3]), .we_b1_o(we1[3]), .d_b1_o(d8_raw));

   assign d1[3] = {96'b0, d8_raw};

   // Cycle counter: after edge e of a run the bench is in cycle e+1
   always @(posedge clk) cyc <= cyc + 1;

   // BRAM0 model: registered read plus extra delay stages per instance latency
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (ce0[i] === 1'b1) pipe[i][0] <= mem0[a0[i]];
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   // Monitor: logs reads, writes and done pulses; counts interface rule violations
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we0[i] !== 1'b0 || we1[i] !== ce1[i] || (ce0[i] !== 1'b1 && a0[i] !== 8'h00) ||
             (ce1[i] !== 1'b1 && (a1[i] !== 8'h00 || d1[i] !== 128'h0)))
            bad[i] <= bad[i] + 1;
         if (ce0[i] === 1'b1 && rd_n[i] < 64) begin
            ra[i][rd_n[i]] <= a0[i];
            rd_n[i] <= rd_n[i] + 1;
         end
         if (ce1[i] === 1'b1 && wr_n[i] < 64) begin
            wa[i][wr_n[i]] <= a1[i];
            wd[i][wr_n[i]] <= d1[i];
            wc[i][wr_n[i]] <= cyc;
            wr_n[i] <= wr_n[i] + 1;
         end
         if (done[i] === 1'b1 && dn_n[i] < 64) begin
            dc[i][dn_n[i]] <= cyc;
            dn_n[i] <= dn_n[i] + 1;
         end
      end
   end

   task automatic mark();
      for (int i = 0; i < 4; i++) begin
         r0[i] = rd_n[i];
         w0[i] = wr_n[i];
         n0[i] = dn_n[i];
      end
   endtask

   // Issue a one-cycle start; on return the bench is in cycle 1 of the run
   task automatic go(input logic [15:0] n, input logic m, input logic [7:0] rb, input logic [7:0] wb);
      @(negedge clk);
      run_count = n;
      mode      = m;
      rd_base   = rb;
      wr_base   = wb;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      base  = cyc;
      mark();
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (idle[0] && idle[1] && idle[2] && idle[3]) begin
            ok = 1'b1;
            break;
         end
      end
      @(negedge clk);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL wait_idle: instances still busy after 60 cycles, required all idle");
      end
   endtask

   function automatic int rel(input int stamp);
      return stamp - base + 1;
   endfunction

   task automatic test_reset();
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({idle[0], busy[0], done[0], ce0[0], we0[0], ce1[0], we1[0]} !== 7'b1000000) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 1000000",
                  {idle[0], busy[0], done[0], ce0[0], we0[0], ce1[0], we1[0]});
      end
      checks++;
      if (a0[0] !== 8'h00 || a1[0] !== 8'h00 || d1[0] !== 128'h0) begin
         errors++;
         $display("FAIL reset_buses: a0=%h a1=%h d=%h, required all 0", a0[0], a1[0], d1[0]);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_mode0_sweep();
      mem0[0] = 32'h01020304;
      mem0[1] = 32'h01010101;
      mem0[2] = 32'hFF000010;
      go(16'd3, 1'b0, 8'h00, 8'h00);
      wait_idle();
      checks++;
      if (rd_n[0] - r0[0] != 3 || ra[0][r0[0]] !== 8'h00 || ra[0][r0[0]+1] !== 8'h01 || ra[0][r0[0]+2] !== 8'h02) begin
         errors++;
         $display("FAIL m0_reads: n=%0d first=%h, required 3 reads at 00,01,02", rd_n[0] - r0[0], ra[0][r0[0]]);
      end
      checks++;
      if (wr_n[0] - w0[0] != 3) begin
         errors++;
         $display("FAIL m0_wr_count: got %0d, required 3", wr_n[0] - w0[0]);
      end else begin
         checks++;
         if (wa[0][w0[0]] !== 8'h00 || wa[0][w0[0]+1] !== 8'h01 || wa[0][w0[0]+2] !== 8'h02) begin
            errors++;
            $display("FAIL m0_wr_addr: got %h %h %h, required 00 01 02",
                     wa[0][w0[0]], wa[0][w0[0]+1], wa[0][w0[0]+2]);
         end
         checks++;
         if (wd[0][w0[0]] !== EXP_R0 || wd[0][w0[0]+1] !== EXP_R1 || wd[0][w0[0]+2] !== EXP_R2) begin
            errors++;
            $display("FAIL m0_wr_data: got %h / %h / %h, required %h / %h / %h",
                     wd[0][w0[0]], wd[0][w0[0]+1], wd[0][w0[0]+2], EXP_R0, EXP_R1, EXP_R2);
         end
         checks++;
         if (rel(wc[0][w0[0]]) != 3) begin
            errors++;
            $display("FAIL m0_first_wr_cycle: got %0d, required 3", rel(wc[0][w0[0]]));
         end
      end
      // done_o cycle N+RD_LAT+2 and final sums, for RD_LAT 1, 2, 3
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dn_n[i] - n0[i] != 1 || rel(dc[i][n0[i]]) != 3 + (i + 1) + 2) begin
            errors++;
            $display("FAIL done_cycle_lat%0d: pulses=%0d cycle=%0d, required 1 pulse in cycle %0d",
                     i + 1, dn_n[i] - n0[i], rel(dc[i][n0[i]]), 3 + (i + 1) + 2);
         end
         checks++;
         if (wr_n[i] - w0[i] != 3 || wd[i][w0[i]+2] !== EXP_R2 || rel(wc[i][w0[i]+2]) != 3 + (i + 1) + 1) begin
            errors++;
            $display("FAIL last_wr_lat%0d: n=%0d data=%h cycle=%0d, required 3 writes, last %h in cycle %0d",
                     i + 1, wr_n[i] - w0[i], wd[i][w0[i]+2], rel(wc[i][w0[i]+2]), EXP_R2, 3 + (i + 1) + 1);
         end
      end
   endtask

   task automatic test_mode1();
      go(16'd3, 1'b1, 8'h00, 8'h10);
      wait_idle();
      checks++;
      if (wr_n[0] - w0[0] != 1 || wa[0][w0[0]] !== 8'h10 || wd[0][w0[0]] !== EXP_R2) begin
         errors++;
         $display("FAIL m1_single_write: n=%0d addr=%h data=%h, required 1 write at 10 of %h",
                  wr_n[0] - w0[0], wa[0][w0[0]], wd[0][w0[0]], EXP_R2);
      end
      checks++;
      if (rel(wc[0][w0[0]]) != 5 || rel(dc[0][n0[0]]) != 6) begin
         errors++;
         $display("FAIL m1_timing: write cycle %0d done cycle %0d, required 5 and 6",
                  rel(wc[0][w0[0]]), rel(dc[0][n0[0]]));
      end
      checks++;
      if (wr_n[2] - w0[2] != 1 || rel(wc[2][w0[2]]) != 7) begin
         errors++;
         $display("FAIL m1_lat3_write: n=%0d cycle=%0d, required 1 write in cycle 7",
                  wr_n[2] - w0[2], rel(wc[2][w0[2]]));
      end
   endtask

   task automatic test_zero_count();
      int acc;
      go(16'd0, 1'b0, 8'h00, 8'h00);
      wait_idle();
      checks++;
      if (dn_n[0] - n0[0] != 1 || rel(dc[0][n0[0]]) != 1) begin
         errors++;
         $display("FAIL zero_done: pulses=%0d cycle=%0d, required 1 pulse in cycle 1",
                  dn_n[0] - n0[0], rel(dc[0][n0[0]]));
      end
      acc = 0;
      for (int i = 0; i < 4; i++) acc += (rd_n[i] - r0[i]) + (wr_n[i] - w0[i]);
      checks++;
      if (acc != 0) begin
         errors++;
         $display("FAIL zero_no_access: %0d BRAM accesses, required 0", acc);
      end
   endtask

   task automatic test_wrap();
      mem0[8'hFE] = 32'h80808080;
      mem0[8'hFF] = 32'h80808080;
      mem0[8'h00] = 32'h80808080;
      mem0[8'h01] = 32'h80808080;
      go(16'd4, 1'b0, 8'hFE, 8'hFF);
      wait_idle();
      checks++;
      if (rd_n[3] - r0[3] != 4 || {ra[3][r0[3]], ra[3][r0[3]+1], ra[3][r0[3]+2], ra[3][r0[3]+3]} !== 32'hFEFF0001) begin
         errors++;
         $display("FAIL wrap_rd_addr: n=%0d addrs=%h %h %h %h, required FE FF 00 01", rd_n[3] - r0[3],
                  ra[3][r0[3]], ra[3][r0[3]+1], ra[3][r0[3]+2], ra[3][r0[3]+3]);
      end
      checks++;
      if (wr_n[3] - w0[3] != 4 || {wa[3][w0[3]], wa[3][w0[3]+1], wa[3][w0[3]+2], wa[3][w0[3]+3]} !== 32'hFF000102) begin
         errors++;
         $display("FAIL wrap_wr_addr: n=%0d addrs=%h %h %h %h, required FF 00 01 02", wr_n[3] - w0[3],
                  wa[3][w0[3]], wa[3][w0[3]+1], wa[3][w0[3]+2], wa[3][w0[3]+3]);
      end
      checks++;
      if (wd[3][w0[3]] !== 128'h80808080 || wd[3][w0[3]+1] !== 128'h0 ||
          wd[3][w0[3]+2] !== 128'h80808080 || wd[3][w0[3]+3] !== 128'h0) begin
         errors++;
         $display("FAIL wrap_sums: got %h %h %h %h, required 80808080 0 80808080 0",
                  wd[3][w0[3]][31:0], wd[3][w0[3]+1][31:0], wd[3][w0[3]+2][31:0], wd[3][w0[3]+3][31:0]);
      end
   endtask

   task automatic test_ignored_start();
      mem0[0] = 32'h01020304;
      mem0[1] = 32'h01010101;
      mem0[2] = 32'hFF000010;
      go(16'd3, 1'b0, 8'h00, 8'h00);
      @(negedge clk);                  // cycle 1
      @(negedge clk);                  // cycle 2: RUN
      run_count = 16'd1;
      mode      = 1'b1;
      start     = 1'b1;
      @(negedge clk);                  // cycle 3
      start = 1'b0;
      repeat (3) @(negedge clk);       // cycle 6: DONE
      checks++;
      if (done[0] !== 1'b1) begin
         errors++;
         $display("FAIL ign_done_cycle6: done_o=%b, required 1", done[0]);
      end
      start = 1'b1;
      @(negedge clk);                  // cycle 7
      start = 1'b0;
      checks++;
      if (idle[0] !== 1'b1 || busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL ign_restart: idle=%b busy=%b, required idle=1 busy=0", idle[0], busy[0]);
      end
      wait_idle();
      checks++;
      if (wr_n[0] - w0[0] != 3 || wd[0][w0[0]+2] !== EXP_R2 || dn_n[0] - n0[0] != 1) begin
         errors++;
         $display("FAIL ign_result: writes=%0d last=%h dones=%0d, required 3 writes, last %h, 1 done",
                  wr_n[0] - w0[0], wd[0][w0[0]+2], dn_n[0] - n0[0], EXP_R2);
      end
      go(16'd1, 1'b0, 8'h00, 8'h20);
      wait_idle();
      checks++;
      if (wr_n[0] - w0[0] != 1 || wa[0][w0[0]] !== 8'h20 || wd[0][w0[0]] !== EXP_R0) begin
         errors++;
         $display("FAIL restart_cleared: n=%0d addr=%h data=%h, required 1 write at 20 of %h",
                  wr_n[0] - w0[0], wa[0][w0[0]], wd[0][w0[0]], EXP_R0);
      end
   endtask

   task automatic test_reset_mid_run();
      int acc;
      go(16'd3, 1'b0, 8'h00, 8'h00);
      @(posedge clk);                  // into cycle 2 (k=1)
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({idle[0], busy[0], done[0], ce0[0], ce1[0]} !== 5'b10000 || a0[0] !== 8'h00 || a1[0] !== 8'h00) begin
         errors++;
         $display("FAIL mid_reset_async: idle/busy/done/ce0/ce1=%b a0=%h a1=%h, required 10000 00 00",
                  {idle[0], busy[0], done[0], ce0[0], ce1[0]}, a0[0], a1[0]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      mark();
      repeat (12) @(negedge clk);
      acc = 0;
      for (int i = 0; i < 4; i++) acc += (rd_n[i] - r0[i]) + (wr_n[i] - w0[i]) + (dn_n[i] - n0[i]);
      checks++;
      if (acc != 0 || idle[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_quiet: %0d events after release, idle=%b, required 0 and 1", acc, idle[0]);
      end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) mem0[a] = 32'h0;
      for (int i = 0; i < 4; i++) begin
         rd_n[i] = 0;
         wr_n[i] = 0;
         dn_n[i] = 0;
         bad[i]  = 0;
      end
      test_reset();
      test_mode0_sweep();
      test_mode1();
      test_zero_count();
      test_wrap();
      test_ignored_start();
      test_reset_mid_run();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bad[i] != 0) begin
            errors++;
            $display("FAIL bus_rules_inst%0d: %0d violating cycles, required 0", i, bad[i]);
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
